// File: rtl/scnn_compressor_pkg.sv
// rtl/scnn_compressor_pkg.sv - shared constants and types for the zero-skip encoder
package scnn_compressor_pkg;

   localparam int DATA_W    = 16;
   localparam int MAX_NZ    = 16;
   localparam int IDX_W     = 5;
   localparam int CNT_W     = $clog2(MAX_NZ + 1);
   localparam int DENSE_MAX = 2 ** IDX_W;
   localparam int ECNT_W    = IDX_W + 1;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } enc_state_t;

   typedef logic [MAX_NZ-1:0][DATA_W-1:0] value_arr_t;
   typedef logic [MAX_NZ-1:0][IDX_W-1:0]  index_arr_t;

endpackage

// File: rtl/scnn_compressor_if.sv
// rtl/scnn_compressor_if.sv - dense input stream and compressed output frame handshakes
interface scnn_compressor_if;
   import scnn_compressor_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   value_arr_t        out_values;
   index_arr_t        out_indices;
   logic [CNT_W-1:0]  out_num_nz;
   logic              out_overflow;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_values, out_indices, out_num_nz, out_overflow
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_values, out_indices, out_num_nz, out_overflow
   );

endinterface

// File: rtl/scnn_compressor.sv
// rtl/scnn_compressor.sv - streaming zero-skip encoder producing value/zero-run arrays
module scnn_compressor
   import scnn_compressor_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   scnn_compressor_if.slave bus
);

   localparam logic [CNT_W-1:0]  NZ_FULL    = CNT_W'(MAX_NZ);
   localparam logic [ECNT_W-1:0] DENSE_FULL = ECNT_W'(DENSE_MAX);

   enc_state_t        state, state_nxt;
   value_arr_t        values;
   index_arr_t        indices;
   logic [CNT_W-1:0]  num_nz;
   logic [IDX_W-1:0]  run;
   logic [ECNT_W-1:0] elem_cnt;
   logic              overflow;
   logic              accept, release_frame, in_range, nz_full, is_zero, store;
   logic [MAX_NZ-1:0] slot_we;

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         COLLECT: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && bus.in_last) state_nxt = HOLD;
         end
         HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   assign accept        = bus.in_valid && (state == COLLECT);
   assign release_frame = bus.out_ready && (state == HOLD);
   assign in_range      = (elem_cnt != DENSE_FULL);
   assign nz_full       = (num_nz == NZ_FULL);
   assign is_zero       = (bus.in_data == '0);
   assign store         = accept && in_range && !is_zero && !nz_full;

   // num_nz decoded into a one-hot slot write enable
   always_comb begin
      slot_we = '0;
      for (int i = 0; i < MAX_NZ; i++) begin
         slot_we[i] = store && (num_nz == CNT_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= COLLECT;
         values   <= '0;
         indices  <= '0;
         num_nz   <= '0;
         run      <= '0;
         elem_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (release_frame) begin
            values   <= '0;
            indices  <= '0;
            num_nz   <= '0;
            run      <= '0;
            elem_cnt <= '0;
            overflow <= 1'b0;
         end else if (accept) begin
            if (!in_range) begin
               overflow <= 1'b1;
            end else begin
               elem_cnt <= elem_cnt + 1'b1;
               if (is_zero) begin
                  run <= run + 1'b1;
               end else if (nz_full) begin
                  overflow <= 1'b1;
               end else begin
                  num_nz <= num_nz + 1'b1;
                  run    <= '0;
               end
            end
         end
         for (int i = 0; i < MAX_NZ; i++) begin
            if (slot_we[i]) begin
               values[i]  <= bus.in_data;
               indices[i] <= run;
            end
         end
      end
   end

   assign bus.out_values   = values;
   assign bus.out_indices  = indices;
   assign bus.out_num_nz   = num_nz;
   assign bus.out_overflow = overflow;

endmodule

// File: tb/tb_scnn_compressor.sv
// tb/tb_scnn_compressor.sv - scoreboard bench for the zero-skip encoder
module tb_scnn_compressor;
   import scnn_compressor_pkg::*;

   typedef struct packed {
      value_arr_t       values;
      index_arr_t       indices;
      logic [CNT_W-1:0] num;
      logic             ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   bit   rand_ready = 0;
   bit   gaps = 0;
   exp_t sb[$];

   scnn_compressor_if bus();

   scnn_compressor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int unsigned d[$]);
      exp_t e;
      int   zeros;
      int   n;
      e     = '0;
      zeros = 0;
      n     = 0;
      for (int k = 0; k < d.size(); k++) begin
         if (k >= DENSE_MAX) begin
            e.ovf = 1'b1;
         end else if (d[k] == 0) begin
            zeros++;
         end else if (n < MAX_NZ) begin
            e.values[n]  = d[k][DATA_W-1:0];
            e.indices[n] = zeros[IDX_W-1:0];
            n++;
            zeros = 0;
         end else begin
            e.ovf = 1'b1;
         end
      end
      e.num = n[CNT_W-1:0];
      return e;
   endfunction

   task automatic send(input int unsigned d, input logic last);
      int t;
      t = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d[DATA_W-1:0];
      bus.in_last  = last;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         t++;
         if (t > 500) begin
            check("in_ready_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_frame(input int unsigned d[$]);
      sb.push_back(model(d));
      for (int k = 0; k < d.size(); k++) send(d[k], k == d.size() - 1);
      check("out_valid_latency", bus.out_valid, 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_frame", 1, 0);
            end else begin
               e = sb.pop_front();
               check("num_nz", bus.out_num_nz, e.num);
               check("values", bus.out_values, e.values);
               check("indices", bus.out_indices, e.indices);
               check("overflow", bus.out_overflow, e.ovf);
            end
         end
      end
   end

   initial begin
      int unsigned d[$];
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_num_nz", bus.out_num_nz, 0);
      check("rst_values", bus.out_values, 0);
      check("rst_overflow", bus.out_overflow, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic frame: slots checked against hand-derived constants too
      d = '{0, 0, 5, 0, 7, 9};
      send_frame(d);
      check("t1_num", bus.out_num_nz, 3);
      check("t1_v0", bus.out_values[0], 5);
      check("t1_v1", bus.out_values[1], 7);
      check("t1_v2", bus.out_values[2], 9);
      check("t1_i0", bus.out_indices[0], 2);
      check("t1_i1", bus.out_indices[1], 1);
      check("t1_i2", bus.out_indices[2], 0);
      check("t1_v3_unused", bus.out_values[3], 0);
      drain();

      d = {};
      for (int k = 0; k < 32; k++) d.push_back(0);
      send_frame(d);
      check("t2_num", bus.out_num_nz, 0);
      check("t2_ovf", bus.out_overflow, 0);
      drain();

      d = {};
      for (int k = 1; k <= 20; k++) d.push_back(k);
      send_frame(d);
      check("t3_num", bus.out_num_nz, 16);
      check("t3_ovf", bus.out_overflow, 1);
      check("t3_v15", bus.out_values[15], 16);
      drain();

      // 33 elements: last one lies beyond the dense frame size
      d = {};
      for (int k = 0; k < 32; k++) d.push_back(0);
      d.push_back(1);
      send_frame(d);
      check("dense_ovf", bus.out_overflow, 1);
      drain();

      d = '{42};
      send_frame(d);
      drain();

      // consumer stall holds the frame and blocks input
      bus.out_ready = 1'b0;
      d = {};
      for (int k = 1; k <= 17; k++) d.push_back(k * 3);
      send_frame(d);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("hold_in_ready", bus.in_ready, 0);
         check("hold_out_valid", bus.out_valid, 1);
         check("hold_num", bus.out_num_nz, 16);
         check("hold_ovf", bus.out_overflow, 1);
         check("hold_v0", bus.out_values[0], 3);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      d = '{3, 0, 0, 4};
      send_frame(d);
      check("t4_ovf_cleared", bus.out_overflow, 0);
      check("t4_i1", bus.out_indices[1], 2);
      drain();

      // reset in the middle of a frame discards it
      send(11, 1'b0);
      send(0, 1'b0);
      send(12, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_num", bus.out_num_nz, 0);
      check("mid_rst_values", bus.out_values, 0);
      check("mid_rst_indices", bus.out_indices, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      d = '{0, 8, 0, 0, 0, 6};
      send_frame(d);
      drain();

      rand_ready = 1;
      gaps       = 1;
      for (int f = 0; f < 1000; f++) begin
         int len;
         int pz;
         d   = {};
         len = $urandom_range(1, 36);
         pz  = $urandom_range(0, 4);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) < pz) d.push_back(0);
            else d.push_back($urandom_range(1, 65535));
         end
         send_frame(d);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
